mux_rr_arbiter: RTL and testbench

//  Shares the 2:1 mux datapath (mux_2to1) between two streaming requesters, A and B.

---
 rtl/mux_arb_pkg.sv | 14 +
 rtl/mux_2to1.sv | 14 +
 rtl/mux_rr_arbiter.sv | 123 ++++++++++++
 tb/tb_mux_rr_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the round-robin burst arbiter.
// State encoding and mux select values.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_A = 2'd1,
    ST_GRANT_B = 2'd2
  } state_e;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux_2to1.sv
// Plain 2:1 multiplexer, shared datapath for both requesters.
// sel=0 passes d0, sel=1 passes d1.
module mux_2to1 #(
  parameter int W = 4
) (
  input  logic         sel,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  output logic [W-1:0] y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin burst arbiter over a shared 2:1 mux.
// Grants whole bursts and registers the selected beat.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_last,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_last,
  output logic             b_ready,
  output logic             y_valid,
  output logic [WIDTH-1:0] y_data,
  output logic             y_last,
  input  logic             y_ready,
  output logic             sel_o,
  output logic             busy_o
);

  state_e           state_q, state_d;
  logic             prio_q, prio_d;
  logic             sel_q, sel_d;
  logic             y_valid_q, y_valid_d;
  logic [WIDTH-1:0] y_data_q, y_data_d;
  logic             y_last_q, y_last_d;

  logic             out_free;
  logic             a_xfer, b_xfer;
  logic [WIDTH:0]   m_out;

  mux_2to1 #(.W(WIDTH + 1)) u_mux (
    .sel (sel_q),
    .d0  ({a_last, a_data}),
    .d1  ({b_last, b_data}),
    .y   (m_out)
  );

  // Handshake: only the granted side sees ready, gated by output space.
  always_comb begin
    out_free = !y_valid_q || y_ready;
    a_ready  = (state_q == ST_GRANT_A) && out_free;
    b_ready  = (state_q == ST_GRANT_B) && out_free;
    a_xfer   = a_valid && a_ready;
    b_xfer   = b_valid && b_ready;
  end

  // Arbitration: pick by priority in IDLE, release on accepted last beat.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    sel_d   = sel_q;
    unique case (state_q)
      ST_IDLE: begin
        if (a_valid && (!b_valid || prio_q == SEL_A)) begin
          state_d = ST_GRANT_A;
          sel_d   = SEL_A;
        end else if (b_valid) begin
          state_d = ST_GRANT_B;
          sel_d   = SEL_B;
        end
      end
      ST_GRANT_A: begin
        if (a_xfer && a_last) begin
          state_d = ST_IDLE;
          prio_d  = SEL_B;
        end
      end
      ST_GRANT_B: begin
        if (b_xfer && b_last) begin
          state_d = ST_IDLE;
          prio_d  = SEL_A;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output stage: load on transfer, clear on drain, else hold.
  always_comb begin
    y_valid_d = y_valid_q;
    y_data_d  = y_data_q;
    y_last_d  = y_last_q;
    if (a_xfer || b_xfer) begin
      y_valid_d = 1'b1;
      y_data_d  = m_out[WIDTH-1:0];
      y_last_d  = m_out[WIDTH];
    end else if (y_ready) begin
      y_valid_d = 1'b0;
    end
  end

  // State, priority, select and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      prio_q    <= SEL_A;
      sel_q     <= SEL_A;
      y_valid_q <= 1'b0;
      y_data_q  <= '0;
      y_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      sel_q     <= sel_d;
      y_valid_q <= y_valid_d;
      y_data_q  <= y_data_d;
      y_last_q  <= y_last_d;
    end
  end

  assign y_valid = y_valid_q;
  assign y_data  = y_data_q;
  assign y_last  = y_last_q;
  assign sel_o   = sel_q;
  assign busy_o  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter.
// Cycle vectors plus a beat scoreboard on the output port.
module tb_mux_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic       a_valid, a_last, a_ready;
  logic [3:0] a_data;
  logic       b_valid, b_last, b_ready;
  logic [3:0] b_data;
  logic       y_valid, y_last, y_ready;
  logic [3:0] y_data;
  logic       sel_o, busy_o;

  int ntests = 0;
  int nfail  = 0;

  logic [4:0] exp_q[$];

  mux_rr_arbiter #(.WIDTH(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_valid (a_valid),
    .a_data  (a_data),
    .a_last  (a_last),
    .a_ready (a_ready),
    .b_valid (b_valid),
    .b_data  (b_data),
    .b_last  (b_last),
    .b_ready (b_ready),
    .y_valid (y_valid),
    .y_data  (y_data),
    .y_last  (y_last),
    .y_ready (y_ready),
    .sel_o   (sel_o),
    .busy_o  (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       av;
    logic [3:0] ad;
    logic       al;
    logic       yr;
    logic [9:0] exp;
  } vec_t;

  function automatic logic [9:0] ex(
    logic ar, logic br, logic yv, logic [3:0] yd,
    logic yl, logic sl, logic bz);
    return {ar, br, yv, yd, yl, sl, bz};
  endfunction

  function automatic logic [9:0] obs();
    return {a_ready, b_ready, y_valid, y_data,
            y_last, sel_o, busy_o};
  endfunction

  task automatic chk(string nm, logic [31:0] got,
                     logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted output beat must match the queue head.
  always @(negedge clk) begin
    if (rst_n && y_valid && y_ready) begin
      ntests++;
      if (exp_q.size() == 0) begin
        nfail++;
        $display("FAIL sb_extra: got %h, expected none",
                 {y_last, y_data});
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        if ({y_last, y_data} !== e) begin
          nfail++;
          $display("FAIL sb_beat: got %h, expected %h",
                   {y_last, y_data}, e);
        end
      end
    end
  end

  task automatic do_reset();
    rst_n   = 1'b0;
    a_valid = 0; a_data = 0; a_last = 0;
    b_valid = 0; b_data = 0; b_last = 0;
    y_ready = 1'b1;
    #2;
    chk("reset_outs", 32'(obs()), 32'(10'd0));
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain(string nm);
    repeat (4) tick();
    chk(nm, exp_q.size(), 0);
  endtask

  vec_t t1[6];

  initial begin
    rst_n = 1'b1;
    #1;
    do_reset();

    // Test 1: single A burst, one cycle per row.
    t1[0] = '{1, 4'h1, 0, 1, ex(0,0,0,4'h0,0,0,0)};
    t1[1] = '{1, 4'h1, 0, 1, ex(1,0,0,4'h0,0,0,1)};
    t1[2] = '{1, 4'h2, 0, 1, ex(1,0,1,4'h1,0,0,1)};
    t1[3] = '{1, 4'h3, 1, 1, ex(1,0,1,4'h2,0,0,1)};
    t1[4] = '{0, 4'h0, 0, 1, ex(0,0,1,4'h3,1,0,0)};
    t1[5] = '{0, 4'h0, 0, 1, ex(0,0,0,4'h3,1,0,0)};
    exp_q.push_back(5'h01);
    exp_q.push_back(5'h02);
    exp_q.push_back(5'h13);
    for (int i = 0; i < 6; i++) begin
      a_valid = t1[i].av;
      a_data  = t1[i].ad;
      a_last  = t1[i].al;
      y_ready = t1[i].yr;
      #1;
      chk($sformatf("t1_row%0d", i), 32'(obs()),
          32'(t1[i].exp));
      tick();
    end
    drain("t1_drain");

    // Test 2: both valid, A then B, then A again.
    do_reset();
    a_valid = 1; a_data = 4'h7; a_last = 1;
    b_valid = 1; b_data = 4'h8; b_last = 1;
    exp_q.push_back(5'h17);
    exp_q.push_back(5'h18);
    #1;
    chk("t2_idle", {a_ready, b_ready}, 2'b00);
    tick();
    chk("t2_grant_a", {a_ready, b_ready, sel_o, busy_o}, 4'b1001);
    tick();
    a_valid = 0;
    #1;
    chk("t2_gap", {busy_o, b_ready}, 2'b00);
    tick();
    chk("t2_grant_b", {a_ready, b_ready, sel_o, busy_o}, 4'b0111);
    tick();
    a_valid = 1;
    exp_q.push_back(5'h17);
    exp_q.push_back(5'h18);
    #1;
    chk("t2_idle_sel_hold", {busy_o, sel_o}, 2'b01);
    tick();
    chk("t2_regrant_a", {a_ready, b_ready, sel_o}, 3'b100);
    tick();
    a_valid = 0;
    #1;
    tick();
    chk("t2_regrant_b", {a_ready, b_ready, sel_o}, 3'b011);
    tick();
    b_valid = 0;
    drain("t2_drain");

    // Test 3: backpressure holds the output beat.
    do_reset();
    a_valid = 1; a_data = 4'h5; a_last = 0;
    exp_q.push_back(5'h05);
    exp_q.push_back(5'h16);
    #1;
    tick();
    chk("t3_rdy", a_ready, 1);
    tick();
    y_ready = 0; a_data = 4'h6; a_last = 1;
    #1;
    chk("t3_hold1", {y_valid, y_data, a_ready}, {1'b1, 4'h5, 1'b0});
    tick();
    chk("t3_hold2", {y_valid, y_data, a_ready}, {1'b1, 4'h5, 1'b0});
    y_ready = 1;
    #1;
    chk("t3_release", a_ready, 1);
    tick();
    a_valid = 0;
    #1;
    chk("t3_last", {y_valid, y_last, y_data}, {1'b1, 1'b1, 4'h6});
    tick();
    drain("t3_drain");

    // Test 4: grant locked while A stalls mid-burst.
    do_reset();
    a_valid = 1; a_data = 4'h1; a_last = 0;
    b_valid = 1; b_data = 4'h9; b_last = 1;
    exp_q.push_back(5'h01);
    exp_q.push_back(5'h12);
    exp_q.push_back(5'h19);
    #1;
    tick();
    chk("t4_grant_a", {a_ready, b_ready}, 2'b10);
    tick();
    a_valid = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("t4_lock%0d", i), {b_ready, busy_o}, 2'b01);
      tick();
    end
    a_valid = 1; a_data = 4'h2; a_last = 1;
    #1;
    chk("t4_a_last", {a_ready, b_ready}, 2'b10);
    tick();
    a_valid = 0;
    #1;
    chk("t4_gap", {b_ready, busy_o}, 2'b00);
    tick();
    chk("t4_grant_b", {b_ready, sel_o}, 2'b11);
    tick();
    b_valid = 0;
    drain("t4_drain");

    // Test 5: async reset with a beat held in the output stage.
    do_reset();
    a_valid = 1; a_data = 4'h3; a_last = 0;
    #1;
    tick();
    tick();
    y_ready = 0; a_valid = 0;
    #1;
    chk("t5_pre", {y_valid, busy_o}, 2'b11);
    rst_n = 0;
    #1;
    chk("t5_async", {y_valid, busy_o, a_ready}, 3'b000);
    @(posedge clk);
    #1;
    rst_n = 1; y_ready = 1;
    a_valid = 1; a_data = 4'h4; a_last = 1;
    b_valid = 1; b_data = 4'h5; b_last = 1;
    exp_q.push_back(5'h14);
    exp_q.push_back(5'h15);
    #1;
    chk("t5_idle", {a_ready, b_ready, y_valid}, 3'b000);
    tick();
    chk("t5_prio_a", {a_ready, b_ready}, 2'b10);
    tick();
    a_valid = 0;
    #1;
    tick();
    chk("t5_then_b", b_ready, 1);
    tick();
    b_valid = 0;
    drain("t5_drain");

    // Test 6: alternating single-beat bursts A, B, A.
    do_reset();
    a_valid = 1; a_data = 4'hA; a_last = 1;
    b_valid = 1; b_data = 4'hB; b_last = 1;
    exp_q.push_back(5'h1A);
    exp_q.push_back(5'h1B);
    exp_q.push_back(5'h1C);
    #1;
    tick();
    chk("t6_a", {a_ready, b_ready}, 2'b10);
    tick();
    a_data = 4'hC;
    #1;
    chk("t6_gap1", busy_o, 0);
    tick();
    chk("t6_b", {a_ready, b_ready, sel_o}, 3'b011);
    tick();
    b_valid = 0;
    #1;
    tick();
    chk("t6_a2", {a_ready, sel_o}, 2'b10);
    tick();
    a_valid = 0;
    drain("t6_drain");

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
